// File: rtl/ring_pkg.sv
// Shared definitions for the ring-oscillator measurement master: CSR offsets,
// CONTROL bit positions and the sequencer state encoding.
package ring_pkg;

  localparam logic [7:0] OFS_COUNT   = 8'h00;
  localparam logic [7:0] OFS_CONTROL = 8'h04;
  localparam logic [7:0] OFS_TRIMA   = 8'h08;
  localparam logic [7:0] OFS_TRIMB   = 8'h0c;

  localparam int CTRL_RESETB_BIT = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int CTRL_CLKMUX_LSB = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_TRIMA,
    ST_WR_TRIMB,
    ST_WR_RST,
    ST_WR_RUN,
    ST_GATE,
    ST_WR_STOP,
    ST_RD_COUNT,
    ST_DONE
  } ring_state_e;

endpackage

// File: rtl/wb_single_xfer.sv
// Issues one classic Wishbone single transfer per request and reports completion.
// With RING_MEAS_TIMEOUT_EN defined, an ack watchdog abandons a stalled transfer.
module wb_single_xfer
  import ring_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] rdata_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        tmo;

`ifdef RING_MEAS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_q;

  assign tmo = cyc_q && !wbm_ack_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (cyc_q && !wbm_ack_i && !tmo) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end
`else
  logic wd_unused;
  assign wd_unused = (TIMEOUT_CYCLES == 0);
  assign tmo       = 1'b0;
`endif

  // Bus signals are cleared on completion so an idle bus reads as all-zero.
  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q && (wbm_ack_i || tmo)) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
    end else if (!cyc_q && req_i) begin
      cyc_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign done_o    = cyc_q && wbm_ack_i;
  assign timeout_o = tmo;
  assign rdata_o   = wbm_dat_i;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: rtl/ring_meas_master.sv
// Wishbone initiator running one ring-oscillator measurement (trim, reset, run,
// gate, stop, read count). Optional ack watchdog: define RING_MEAS_TIMEOUT_EN.
module ring_meas_master
  import ring_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TRIM_BITS      = 28,
  parameter int          CLKMUX_BITS    = 3,
  parameter int          GATE_BITS      = 16,
  parameter int          COUNT_BITS     = 17,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rstb_i,
  input  logic                   start_i,
  input  logic [TRIM_BITS-1:0]   trim_a_i,
  input  logic [TRIM_BITS-1:0]   trim_b_i,
  input  logic [CLKMUX_BITS-1:0] clkmux_i,
  input  logic [GATE_BITS-1:0]   gate_cycles_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [COUNT_BITS-1:0]  count_o,
  output logic                   error_o,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic                   wbm_we_o,
  output logic [3:0]             wbm_sel_o,
  output logic [31:0]            wbm_adr_o,
  output logic [31:0]            wbm_dat_o,
  input  logic [31:0]            wbm_dat_i,
  input  logic                   wbm_ack_i
);

  ring_state_e            state_q, state_d;
  logic [TRIM_BITS-1:0]   trim_a_q, trim_b_q;
  logic [CLKMUX_BITS-1:0] clkmux_q;
  logic [GATE_BITS-1:0]   gate_q, gate_cnt_q, gate_eff;
  logic [COUNT_BITS-1:0]  count_q;
  logic                   accept;

  logic        xfer_req, xfer_we, xfer_done, xfer_tmo;
  logic [7:0]  xfer_ofs;
  logic [31:0] xfer_adr, xfer_wdat, xfer_rdata;
  logic        rdata_unused;

  function automatic logic [31:0] ctrl_word(input logic resetb, input logic run,
                                            input logic [CLKMUX_BITS-1:0] mux);
    logic [31:0] w;
    w = '0;
    w[CTRL_CLKMUX_LSB +: CLKMUX_BITS] = mux;
    w[CTRL_START_BIT]  = run;
    w[CTRL_RESETB_BIT] = resetb;
    return w;
  endfunction

  assign gate_eff     = (gate_q == '0) ? GATE_BITS'(1) : gate_q;
  assign xfer_adr     = BASE_ADDR + {24'h0, xfer_ofs};
  assign rdata_unused = ^xfer_rdata[31:COUNT_BITS];

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    xfer_req  = 1'b0;
    xfer_we   = 1'b1;
    xfer_ofs  = OFS_COUNT;
    xfer_wdat = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = ST_WR_TRIMA;
        end
      end
      ST_WR_TRIMA: begin
        xfer_req  = 1'b1;
        xfer_ofs  = OFS_TRIMA;
        xfer_wdat = 32'(trim_a_q);
        if (xfer_done) state_d = ST_WR_TRIMB;
      end
      ST_WR_TRIMB: begin
        xfer_req  = 1'b1;
        xfer_ofs  = OFS_TRIMB;
        xfer_wdat = 32'(trim_b_q);
        if (xfer_done) state_d = ST_WR_RST;
      end
      ST_WR_RST: begin
        xfer_req  = 1'b1;
        xfer_ofs  = OFS_CONTROL;
        xfer_wdat = ctrl_word(1'b0, 1'b0, clkmux_q);
        if (xfer_done) state_d = ST_WR_RUN;
      end
      ST_WR_RUN: begin
        xfer_req  = 1'b1;
        xfer_ofs  = OFS_CONTROL;
        xfer_wdat = ctrl_word(1'b1, 1'b1, clkmux_q);
        if (xfer_done) state_d = ST_GATE;
      end
      ST_GATE: begin
        if (gate_cnt_q <= GATE_BITS'(1)) state_d = ST_WR_STOP;
      end
      ST_WR_STOP: begin
        xfer_req  = 1'b1;
        xfer_ofs  = OFS_CONTROL;
        xfer_wdat = ctrl_word(1'b1, 1'b0, clkmux_q);
        if (xfer_done) state_d = ST_RD_COUNT;
      end
      ST_RD_COUNT: begin
        xfer_req = 1'b1;
        xfer_we  = 1'b0;
        xfer_ofs = OFS_COUNT;
        if (xfer_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A stalled transfer aborts the whole sequence.
    if (xfer_tmo) state_d = ST_DONE;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstb_i) begin
    if (!wb_rstb_i) begin
      state_q    <= ST_IDLE;
      trim_a_q   <= '0;
      trim_b_q   <= '0;
      clkmux_q   <= '0;
      gate_q     <= '0;
      gate_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        trim_a_q <= trim_a_i;
        trim_b_q <= trim_b_i;
        clkmux_q <= clkmux_i;
        gate_q   <= gate_cycles_i;
      end
      if (state_q == ST_WR_RUN && xfer_done) begin
        gate_cnt_q <= gate_eff;
      end else if (state_q == ST_GATE) begin
        gate_cnt_q <= gate_cnt_q - GATE_BITS'(1);
      end
      if (state_q == ST_RD_COUNT && xfer_done) begin
        count_q <= xfer_rdata[COUNT_BITS-1:0];
      end
    end
  end

`ifdef RING_MEAS_TIMEOUT_EN
  logic error_q;
  always_ff @(posedge wb_clk_i or negedge wb_rstb_i) begin
    if (!wb_rstb_i) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if (xfer_tmo) begin
      error_q <= 1'b1;
    end
  end
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign count_o = count_q;

  wb_single_xfer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_xfer (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rstb_i),
    .req_i    (xfer_req),
    .we_i     (xfer_we),
    .adr_i    (xfer_adr),
    .dat_i    (xfer_wdat),
    .done_o   (xfer_done),
    .timeout_o(xfer_tmo),
    .rdata_o  (xfer_rdata),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

endmodule

// File: tb/tb_ring_meas_master.sv
// Randomized self-checking bench for ring_meas_master with a delayed-ack slave
// and a transaction-level reference model of the measurement sequence.
module tb_ring_meas_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [27:0] ta, tb;
  logic [2:0]  cm;
  logic [15:0] gate;
  logic        busy, done, err;
  logic [16:0] count;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dato, dati;

  always #5 clk = ~clk;

  ring_meas_master dut (
    .wb_clk_i(clk), .wb_rstb_i(rst_n), .start_i(start),
    .trim_a_i(ta), .trim_b_i(tb), .clkmux_i(cm), .gate_cycles_i(gate),
    .busy_o(busy), .done_o(done), .count_o(count), .error_o(err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_dat_i(dati), .wbm_ack_i(ack)
  );

  int total = 0;
  int bad   = 0;

  // Slave: acks after a random number of wait cycles; can refuse TRIMB or ack spuriously.
  int unsigned max_dly = 0, cur_dly = 0, wcnt = 0;
  logic        hang = 1'b0, spurious = 1'b0;
  logic [31:0] rdata_val = 32'h0;

  assign dati = rdata_val;
  assign ack  = spurious | (cyc && !(hang && adr == BASE + 32'h0c) && (wcnt == cur_dly));

  always @(posedge clk) begin
    if (!cyc) begin
      wcnt    <= 0;
      cur_dly <= $urandom_range(max_dly, 0);
    end else if (ack) begin
      wcnt <= 0;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: completed transfers plus protocol violation counters.
  logic        q_we[$];
  logic [31:0] q_adr[$], q_dat[$];
  int          q_wait[$];
  int unsigned q_t[$];
  int   done_cnt = 0, unstable = 0, gap_viol = 0, bus_viol = 0;
  logic tmo_ok = 1'b0;
  logic p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cyc && ack) begin
        q_we.push_back(we); q_adr.push_back(adr); q_dat.push_back(dato);
        q_wait.push_back(int'(wcnt)); q_t.push_back(cyc_n);
      end
      if (stb !== cyc || (cyc && sel !== 4'hf)) bus_viol++;
      if (p_cyc && p_ack && cyc) gap_viol++;
      if (p_cyc && !p_ack && !tmo_ok &&
          !(cyc && we == p_we && adr == p_adr && dato == p_dat)) unstable++;
      if (done) done_cnt++;
    end
    p_cyc = cyc & rst_n; p_ack = ack; p_we = we; p_adr = adr; p_dat = dato;
  end

  // Reference model: the six transfers a measurement must perform.
  logic [64:0] exp_tr [6];

  function automatic void build_exp(input logic [27:0] a, input logic [27:0] b, input logic [2:0] m);
    logic [31:0] c;
    c = {21'h0, m, 8'h00};
    exp_tr[0] = {1'b1, BASE + 32'h08, {4'h0, a}};
    exp_tr[1] = {1'b1, BASE + 32'h0c, {4'h0, b}};
    exp_tr[2] = {1'b1, BASE + 32'h04, c};
    exp_tr[3] = {1'b1, BASE + 32'h04, c | 32'h3};
    exp_tr[4] = {1'b1, BASE + 32'h04, c | 32'h1};
    exp_tr[5] = {1'b0, BASE, 32'h0};
  endfunction

  function automatic int exp_latency(input logic [15:0] g);
    int l;
    l = (g == 0) ? 1 : int'(g);
    foreach (q_wait[i]) l += 2 + q_wait[i];
    return l;
  endfunction

  task automatic clear_mon();
    q_we.delete(); q_adr.delete(); q_dat.delete(); q_wait.delete(); q_t.delete();
    done_cnt = 0; unstable = 0; gap_viol = 0; bus_viol = 0;
  endtask

  task automatic run_meas(input logic [27:0] a, input logic [27:0] b, input logic [2:0] m,
                          input logic [15:0] g, input logic [31:0] rd, input int unsigned md,
                          output int lat);
    int unsigned t0;
    bit seen;
    @(negedge clk);
    clear_mon();
    max_dly = md; rdata_val = rd;
    ta = a; tb = b; cm = m; gate = g; start = 1'b1;
    @(posedge clk); #1 t0 = cyc_n;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 4000; k++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    lat = int'(cyc_n - t0);
    total++;
    if (!seen) begin bad++; $display("FAIL run_done: done_o never seen, waited %0d cycles", lat); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ta = '0; tb = '0; cm = '0; gate = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      spurious = (i >= 5 && i < 10);
      @(negedge clk);
      total++;
      if ({cyc, stb, we, sel, adr, dato, busy, done, count, err} !== '0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h busy=%b done=%b count=%h err=%b, all zero required",
                 i, cyc, stb, we, sel, adr, dato, busy, done, count, err);
      end
    end
    spurious = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    build_exp(28'h123_4567, 28'h0ab_cdef, 3'd5);
    run_meas(28'h123_4567, 28'h0ab_cdef, 3'd5, 16'd10, 32'h0001_2345, 0, lat);
    total++;
    if (q_we.size() != 6) begin bad++; $display("FAIL basic_ntr: got %0d transfers exp 6", q_we.size()); end
    for (int i = 0; i < 6 && i < q_we.size(); i++) begin
      total++;
      if ({q_we[i], q_adr[i], q_we[i] ? q_dat[i] : 32'h0} !== exp_tr[i]) begin
        bad++; $display("FAIL basic_tr[%0d]: got we=%b adr=%h dat=%h exp %h", i, q_we[i], q_adr[i], q_dat[i], exp_tr[i]);
      end
    end
    total++;
    if (count !== 17'h1_2345) begin bad++; $display("FAIL basic_count: got %h exp 12345", count); end
    total++;
    if (lat != exp_latency(16'd10)) begin bad++; $display("FAIL basic_latency: got %0d exp %0d", lat, exp_latency(16'd10)); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      bad++; $display("FAIL basic_end: busy=%b done_pulses=%0d exp busy=0 pulses=1", busy, done_cnt);
    end
  endtask

  task automatic test_random_wait();
    int lat;
    logic [27:0] a, b; logic [2:0] m; logic [15:0] g; logic [31:0] rd;
    for (int it = 0; it < 4; it++) begin
      a = 28'($urandom); b = 28'($urandom); m = 3'($urandom);
      g = 16'($urandom_range(20, 0)); rd = $urandom;
      build_exp(a, b, m);
      run_meas(a, b, m, g, rd, 5, lat);
      total++;
      if (q_we.size() != 6) begin bad++; $display("FAIL rand_ntr[%0d]: got %0d exp 6", it, q_we.size()); end
      for (int i = 0; i < 6 && i < q_we.size(); i++) begin
        total++;
        if ({q_we[i], q_adr[i], q_we[i] ? q_dat[i] : 32'h0} !== exp_tr[i]) begin
          bad++; $display("FAIL rand_tr[%0d.%0d]: got we=%b adr=%h dat=%h exp %h", it, i, q_we[i], q_adr[i], q_dat[i], exp_tr[i]);
        end
      end
      total++;
      if (count !== rd[16:0]) begin bad++; $display("FAIL rand_count[%0d]: got %h exp %h", it, count, rd[16:0]); end
      total++;
      if (lat != exp_latency(g)) begin bad++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", it, lat, exp_latency(g)); end
      total++;
      if (unstable != 0 || gap_viol != 0 || bus_viol != 0) begin
        bad++; $display("FAIL rand_protocol[%0d]: unstable=%0d gap=%0d bus=%0d exp all 0", it, unstable, gap_viol, bus_viol);
      end
    end
  endtask

  task automatic test_start_ignored();
    int unsigned t0;
    bit seen;
    logic [27:0] a, b; logic [2:0] m; logic [15:0] g;
    a = 28'($urandom); b = 28'($urandom); m = 3'($urandom); g = 16'd4;
    build_exp(a, b, m);
    @(negedge clk);
    clear_mon(); max_dly = 2; rdata_val = 32'h0000_0abc;
    ta = a; tb = b; cm = m; gate = g; start = 1'b1;
    @(posedge clk); #1 t0 = cyc_n;
    seen = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      ta = 28'($urandom); tb = 28'($urandom); cm = 3'($urandom); gate = 16'($urandom_range(30, 0));
      if (done) begin seen = 1; break; end
    end
    total++;
    if (!seen || int'(cyc_n - t0) != exp_latency(g)) begin
      bad++; $display("FAIL ign_latency: done_seen=%0d got %0d exp %0d", seen, cyc_n - t0, exp_latency(g));
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ign_done_start: busy=%b after DONE exp 0", busy); end
    start = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt != 1 || q_we.size() != 6) begin
      bad++; $display("FAIL ign_count: done_pulses=%0d transfers=%0d exp 1 and 6", done_cnt, q_we.size());
    end
    for (int i = 0; i < 6 && i < q_we.size(); i++) begin
      total++;
      if ({q_we[i], q_adr[i], q_we[i] ? q_dat[i] : 32'h0} !== exp_tr[i]) begin
        bad++; $display("FAIL ign_tr[%0d]: got we=%b adr=%h dat=%h exp %h", i, q_we[i], q_adr[i], q_dat[i], exp_tr[i]);
      end
    end
  endtask

  task automatic test_gate_zero();
    int lat;
    int sp[2];
    for (int j = 0; j < 2; j++) begin
      run_meas(28'h0, 28'h1, 3'd2, 16'(j), 32'h5, 0, lat);
      sp[j] = (q_t.size() == 6) ? int'(q_t[4] - q_t[3]) : -1;
      total++;
      if (sp[j] != 3) begin bad++; $display("FAIL gate%0d_spacing: got %0d exp 3", j, sp[j]); end
    end
    total++;
    if (sp[0] != sp[1]) begin bad++; $display("FAIL gate_equal: gate0=%0d gate1=%0d exp equal", sp[0], sp[1]); end
  endtask

  task automatic test_reset_midxfer();
    bit seen, stray;
    @(negedge clk);
    max_dly = 5; ta = 28'h77; tb = 28'h88; cm = 3'd1; gate = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (cyc) begin seen = 1; break; end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (!seen || cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0 || count !== '0) begin
      bad++; $display("FAIL async_reset: seen_cyc=%0d cyc=%b stb=%b busy=%b count=%h exp cyc/stb/busy/count 0", seen, cyc, stb, busy, count);
    end
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cyc || busy) stray = 1;
    end
    total++;
    if (stray) begin bad++; $display("FAIL reset_no_resume: bus or busy active after reset, exp idle"); end
  endtask

`ifdef RING_MEAS_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    int unsigned t_rise, t_fall;
    logic [16:0] prev;
    bit ok;
    run_meas(28'h1, 28'h2, 3'd3, 16'd2, 32'h0000_4321, 1, lat);
    prev = count;
    @(negedge clk);
    clear_mon(); hang = 1'b1; tmo_ok = 1'b1; max_dly = 0;
    ta = 28'h3; tb = 28'h4; cm = 3'd6; gate = 16'd2; rdata_val = 32'h0001_ffff; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 0; t_rise = 0; t_fall = 0;
    for (int k = 0; k < 100; k++) begin
      if (cyc && adr == BASE + 32'h0c) begin ok = 1; t_rise = cyc_n; break; end
      @(negedge clk);
    end
    for (int k = 0; k < 1000 && ok; k++) begin
      @(negedge clk);
      if (!cyc) begin t_fall = cyc_n; break; end
    end
    total++;
    if (t_fall - t_rise != 256) begin bad++; $display("FAIL tmo_len: cyc held %0d cycles exp 256", t_fall - t_rise); end
    total++;
    if (err !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL tmo_flags: err=%b done=%b exp 1 1", err, done); end
    @(negedge clk);
    total++;
    if (count !== prev || q_we.size() != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL tmo_state: count=%h exp %h transfers=%0d exp 1 busy=%b exp 0", count, prev, q_we.size(), busy);
    end
    hang = 1'b0; tmo_ok = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL tmo_clear: err=%b exp 0 after start", err); end
    @(negedge clk); start = 1'b0;
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok || count !== 17'h1_ffff) begin bad++; $display("FAIL tmo_recover: done=%0d count=%h exp 1ffff", ok, count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random_wait();
    test_start_ignored();
    test_gate_zero();
    test_reset_midxfer();
`ifdef RING_MEAS_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
